regfile_2r1w: RTL and testbench

Parametrised general-purpose register file for the RISC-V core datapath: two combinational read ports and one synchronous write port. Entry 0 is hardwired to zero. After reset, a clear sequencer zeroes every entry one per cycle and holds `busy` high until the file is valid. It feeds rs1/rs2 operands to decode/execute and takes rd writeback.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_read_port.sv | 32 +++
 rtl/regfile_2r1w.sv | 87 ++++++++
 tb/tb_regfile_2r1w.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the 2-read/1-write register file.
package regfile_pkg;

  localparam int unsigned RF_DATA_W    = 32;
  localparam int unsigned RF_ADDR_W    = 5;
  localparam int unsigned RF_ZERO_ADDR = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, x0/busy force to zero, and the
// optional same-cycle write bypass selected by REGFILE_BYPASS_EN.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic [ADDR_W-1:0]                    raddr_i,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   entries_i,
  input  logic                                 busy_i,
  input  logic                                 we_i,
  input  logic [ADDR_W-1:0]                    waddr_i,
  input  logic [DATA_W-1:0]                    wdata_i,
  output logic [DATA_W-1:0]                    rdata_o
);

`ifndef REGFILE_BYPASS_EN
  logic unused_wr_path;
  assign unused_wr_path = ^{we_i, waddr_i, wdata_i};
`endif

  always_comb begin
    rdata_o = entries_i[raddr_i];
`ifdef REGFILE_BYPASS_EN
    if (we_i && (waddr_i == raddr_i)) rdata_o = wdata_i;
`endif
    // Zero force wins over bypass: covers both x0 and the clear sequence.
    if (busy_i || (raddr_i == ADDR_W'(RF_ZERO_ADDR))) rdata_o = '0;
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file top: clear sequencer FSM, clear counter, storage for x1..xN.
// Optional same-cycle write bypass on both ports via REGFILE_BYPASS_EN.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [1:DEPTH-1];
  logic [DEPTH-1:0][DATA_W-1:0] entries;
  logic              wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign busy  = (state_q == CLEAR);
  assign wr_en = (state_q == READY) && we && (waddr != ADDR_W'(RF_ZERO_ADDR));

  // Storage has no reset of its own; the clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem_q[cnt_q] <= '0;
    else if (wr_en)       mem_q[waddr] <= wdata;
  end

  always_comb begin
    entries = '0;
    for (int i = 1; i < DEPTH; i++) entries[i] = mem_q[i];
  end

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .raddr_i   (raddr1),
    .entries_i (entries),
    .busy_i    (busy),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .rdata_o   (rdata1)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .raddr_i   (raddr2),
    .entries_i (entries),
    .busy_i    (busy),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .rdata_o   (rdata2)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: array model checked every cycle plus
// hand-computed literal expectations.
module tb_regfile_2r1w;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] raddr1 = '0;
  logic [AW-1:0] raddr2 = '0;
  logic [DW-1:0] rdata1, rdata2;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: file contents plus number of clear edges still owed.
  logic [DW-1:0] m_mem [N];
  int            m_clear_left = 0;
  bit            chk_en = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_clear_left = N - 1;
      for (int i = 0; i < N; i++) m_mem[i] = '0;
    end else if (m_clear_left > 0) begin
      m_clear_left = m_clear_left - 1;
    end else if (we && waddr != 0) begin
      m_mem[waddr] = wdata;
    end
  end

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (m_clear_left > 0 || !rst || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return m_mem[a];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   {31'd0, busy}, {31'd0, (m_clear_left > 0 || !rst)});
      chk("rdata1", rdata1, m_read(raddr1));
      chk("rdata2", rdata2, m_read(raddr2));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(); we = 1'b1; waddr = a; wdata = d;
    step(); we = 1'b0;
  endtask

  task automatic rd_lit(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    step(); raddr1 = a; raddr2 = a;
    @(negedge clk);
    chk({name, "_p1"}, rdata1, exp);
    chk({name, "_p2"}, rdata2, exp);
  endtask

  // Counts negedges with busy high; releases we the moment busy falls.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) n++;
      else begin
        we = 1'b0;
        return;
      end
    end
    chk("busy_timeout", 32'(n), 32'd999);
  endtask

  task automatic sweep_zero(input string name);
    for (int a = 0; a < N; a++) rd_lit(name, AW'(a), '0);
  endtask

  int nb;

  initial begin
    #2 rst = 1'b0;
    @(posedge clk); #1 chk_en = 1'b1;
    raddr1 = 5'd7; raddr2 = 5'd31;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rd1", rdata1, 32'd0);
    step(); step();
    rst = 1'b1;
    count_busy(nb);
    chk("clear_len", 32'(nb), 32'd31);
    sweep_zero("after_clear");

    wr(5'd5, 32'hDEADBEEF);
    rd_lit("x5", 5'd5, 32'hDEADBEEF);

    wr(5'd0, 32'h12345678);
    rd_lit("x0", 5'd0, 32'd0);
    for (int a = 1; a < N; a++)
      rd_lit("no_side", AW'(a), (a == 5) ? 32'hDEADBEEF : 32'd0);

    wr(5'd7, 32'h1111);
    step(); we = 1'b1; waddr = 5'd7; wdata = 32'h2222; raddr1 = 5'd7; raddr2 = 5'd7;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("rdw_same", rdata1, 32'h2222);
`else
    chk("rdw_same", rdata1, 32'h1111);
`endif
    step(); we = 1'b0;
    @(negedge clk);
    chk("rdw_next1", rdata1, 32'h2222);
    chk("rdw_next2", rdata2, 32'h2222);

    step(); rst = 1'b0; raddr1 = 5'd3; raddr2 = 5'd0;
    step();
    we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF;
    rst = 1'b1;
    count_busy(nb);
    chk("clear_len2", 32'(nb), 32'd31);
    rd_lit("x3_clear_we", 5'd3, 32'd0);

    for (int a = 1; a < N; a++) wr(AW'(a), DW'(a));
    rd_lit("fill_x9", 5'd9, 32'd9);
    rd_lit("fill_x31", 5'd31, 32'd31);
    step(); rst = 1'b0;
    step(); step();
    rst = 1'b1;
    count_busy(nb);
    chk("clear_len3", 32'(nb), 32'd31);
    sweep_zero("after_rst");

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
